instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/pc_next.sv | 29 ++
 rtl/instr_fetch.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: data width, fetch states,
// the opcodes understood by the main decoder and the reset NOP word.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // True when the main decoder has a control word for this opcode.
    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection at instruction consume: sequential pc+4 or a word-aligned
// branch target.
module pc_next
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic            unused_target_lsbs;

    // Wraps modulo 2^XLEN by construction; no carry out is kept.
    assign pc_plus4       = pc_i + XLEN'(4);
    assign target_aligned = {redirect_target_i[XLEN-1:2], 2'b00};

    assign unused_target_lsbs = ^redirect_target_i[1:0];

    always_comb begin
        next_pc_o = pc_plus4;
        if (redirect_i) begin
            next_pc_o = target_aligned;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: request a word at pc, wait for the response, then hold
// it for decode until consumed; the consume cycle also selects the next pc.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      instr_op,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_illegal,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target
);

    localparam logic [1:0] S_REQ  = FETCH_REQ;
    localparam logic [1:0] S_WAIT = FETCH_WAIT;
    localparam logic [1:0] S_HOLD = FETCH_HOLD;

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_next_w;

    pc_next u_pc_next (
        .pc_i              (pc_q),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .next_pc_o         (pc_next_w)
    );

    // pc only moves on consume, so it stays the address of the held word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_HOLD;
                    instr_d = imem_rdata;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_next_w;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_addr      = pc_q;
        instr_valid    = (state_q == S_HOLD);
        instr          = instr_q;
        instr_op       = instr_q[6:0];
        instr_pc       = pc_q;
        instr_illegal  = instr_valid && !is_legal_op(instr_q[6:0]);
    end

endmodule
